// File: rtl/accel_poll_sequencer_pkg.sv
// Shared types and constants for the accelerometer poll sequencer.
// ACCEL_DEVID_CHECK_EN prepends a DEVID read (must return 0xE5) to the init table.
package accel_poll_sequencer_pkg;

  localparam int unsigned SYS_CLK_SPEED = 50_000_000;
  localparam int unsigned POLL_HZ       = 100;
  localparam int unsigned READ_BYTES    = 6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT_ISSUE, ST_INIT_WAIT, ST_PERIOD_WAIT,
    ST_RD_ISSUE, ST_RD_WAIT, ST_PUBLISH, ST_ERROR
  } accel_seq_state_e;

  localparam logic [7:0] REG_DEVID       = 8'h00;
  localparam logic [7:0] REG_BW_RATE     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] DATA_FORMAT_INIT = 8'h0B;
  localparam logic [7:0] BW_RATE_INIT     = 8'h0A;
  localparam logic [7:0] POWER_CTL_INIT   = 8'h08;
  localparam logic [7:0] DEVID_EXPECTED   = 8'hE5;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic       r_w;
    logic [7:0] data;
  } i2c_req_t;

`ifdef ACCEL_DEVID_CHECK_EN
  localparam int unsigned INIT_STEPS = 4;
`else
  localparam int unsigned INIT_STEPS = 3;
`endif

  // Request issued at a given init step.
  function automatic i2c_req_t init_req(input logic [2:0] step);
    i2c_req_t   req;
    logic [2:0] w;
    logic       is_write;
`ifdef ACCEL_DEVID_CHECK_EN
    w        = step - 3'd1;
    is_write = (step != 3'd0);
`else
    w        = step;
    is_write = 1'b1;
`endif
    req = '{reg_addr: REG_DEVID, r_w: 1'b1, data: 8'h00};
    if (is_write) begin
      case (w)
        3'd0:    req = '{reg_addr: REG_DATA_FORMAT, r_w: 1'b0, data: DATA_FORMAT_INIT};
        3'd1:    req = '{reg_addr: REG_BW_RATE,     r_w: 1'b0, data: BW_RATE_INIT};
        default: req = '{reg_addr: REG_POWER_CTL,   r_w: 1'b0, data: POWER_CTL_INIT};
      endcase
    end
    return req;
  endfunction

endpackage

// File: rtl/accel_poll_timer.sv
// Reloadable down-counter; tc_c marks the enabled cycle in which the count is zero.
module accel_poll_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] reload,
  output logic             tc_c
);

  logic [WIDTH-1:0] count;

  assign tc_c = en && (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load || tc_c) begin
      count <= reload;
    end else if (en) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/accel_poll_sequencer.sv
// Drives the I2C controller through sensor init and periodic six-byte axis bursts.
// ACCEL_DEVID_CHECK_EN enables the DEVID check ahead of the init writes.
module accel_poll_sequencer
  import accel_poll_sequencer_pkg::*;
#(
  parameter int unsigned POLL_PERIOD_CYCLES = SYS_CLK_SPEED / POLL_HZ,
  parameter int unsigned TIMEOUT_CYCLES     = 200_000,
  parameter logic [6:0]  SENSOR_ADDR        = 7'h1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             i2c_ready,
  input  logic             i2c_finished,
  input  logic [7:0]       i2c_read_data,
  output logic [6:0]       i2c_dev_addr,
  output logic [7:0]       i2c_reg_addr,
  output logic             i2c_r_w,
  output logic [7:0]       i2c_write_data,
  output logic             i2c_start,
  output logic [15:0]      accel_x,
  output logic [15:0]      accel_y,
  output logic [15:0]      accel_z,
  output logic             accel_valid,
  output logic             busy,
  output logic             error,
  output accel_seq_state_e dbg_state
);

  localparam int unsigned PERIOD_W  = $clog2(POLL_PERIOD_CYCLES);
  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [2:0]  INIT_LAST = 3'(INIT_STEPS - 1);
  localparam logic [2:0]  READ_LAST = 3'(READ_BYTES - 1);

  accel_seq_state_e state, state_nx;
  logic [2:0]       idx, idx_nx;
  logic             init_done, init_done_nx;
  i2c_req_t         req, req_nx;
  logic [5:0][7:0]  burst, burst_nx;
  logic [15:0]      x_nx, y_nx, z_nx;
  logic             start_nx, valid_nx;
  logic             period_load_c, period_tc_c, timeout_tc_c, waiting_c, devid_bad_c;

  assign waiting_c = (state == ST_INIT_WAIT) || (state == ST_RD_WAIT);

`ifdef ACCEL_DEVID_CHECK_EN
  assign devid_bad_c = req.r_w && (i2c_read_data != DEVID_EXPECTED);
`else
  assign devid_bad_c = 1'b0;
`endif

  // Period timer free-runs once init completes; terminal counts outside PERIOD_WAIT are dropped.
  accel_poll_timer #(.WIDTH(PERIOD_W)) u_period_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (period_load_c),
    .en     (init_done),
    .reload (PERIOD_W'(POLL_PERIOD_CYCLES - 1)),
    .tc_c   (period_tc_c)
  );

  accel_poll_timer #(.WIDTH(TIMEOUT_W)) u_timeout_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (start_nx),
    .en     (waiting_c),
    .reload (TIMEOUT_W'(TIMEOUT_CYCLES - 1)),
    .tc_c   (timeout_tc_c)
  );

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    init_done_nx  = init_done;
    req_nx        = req;
    burst_nx      = burst;
    x_nx          = accel_x;
    y_nx          = accel_y;
    z_nx          = accel_z;
    start_nx      = 1'b0;
    valid_nx      = 1'b0;
    period_load_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          idx_nx   = 3'd0;
          state_nx = init_done ? ST_PERIOD_WAIT : ST_INIT_ISSUE;
        end
      end
      ST_INIT_ISSUE: begin
        req_nx = init_req(idx);
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (i2c_ready) begin
          start_nx = 1'b1;
          state_nx = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT: begin
        if (i2c_finished) begin
          if (devid_bad_c) begin
            state_nx = ST_ERROR;
          end else if (idx == INIT_LAST) begin
            init_done_nx  = 1'b1;
            period_load_c = 1'b1;
            state_nx      = enable ? ST_PERIOD_WAIT : ST_IDLE;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = enable ? ST_INIT_ISSUE : ST_IDLE;
          end
        end else if (timeout_tc_c) begin
          state_nx = ST_ERROR;
        end
      end
      ST_PERIOD_WAIT: begin
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (period_tc_c) begin
          idx_nx   = 3'd0;
          state_nx = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        req_nx = '{reg_addr: REG_DATAX0 + 8'(idx), r_w: 1'b1, data: 8'h00};
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (i2c_ready) begin
          start_nx = 1'b1;
          state_nx = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (i2c_finished) begin
          burst_nx[idx] = i2c_read_data;
          if (!enable) begin
            state_nx = ST_IDLE;
          end else if (idx == READ_LAST) begin
            state_nx = ST_PUBLISH;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = ST_RD_ISSUE;
          end
        end else if (timeout_tc_c) begin
          state_nx = ST_ERROR;
        end
      end
      ST_PUBLISH: begin
        x_nx     = {burst[1], burst[0]};
        y_nx     = {burst[3], burst[2]};
        z_nx     = {burst[5], burst[4]};
        valid_nx = 1'b1;
        state_nx = enable ? ST_PERIOD_WAIT : ST_IDLE;
      end
      ST_ERROR: begin
        if (!enable) begin
          init_done_nx = 1'b0;
          state_nx     = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      idx          <= 3'd0;
      init_done    <= 1'b0;
      req          <= '0;
      burst        <= '0;
      i2c_dev_addr <= SENSOR_ADDR;
      i2c_start    <= 1'b0;
      accel_x      <= 16'h0000;
      accel_y      <= 16'h0000;
      accel_z      <= 16'h0000;
      accel_valid  <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      init_done    <= init_done_nx;
      req          <= req_nx;
      burst        <= burst_nx;
      i2c_dev_addr <= SENSOR_ADDR;
      i2c_start    <= start_nx;
      accel_x      <= x_nx;
      accel_y      <= y_nx;
      accel_z      <= z_nx;
      accel_valid  <= valid_nx;
      busy         <= (state_nx != ST_IDLE) && (state_nx != ST_ERROR);
      error        <= (state_nx == ST_ERROR);
    end
  end

  assign i2c_reg_addr   = req.reg_addr;
  assign i2c_r_w        = req.r_w;
  assign i2c_write_data = req.data;
  assign dbg_state      = state;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Randomized bench for accel_poll_sequencer with a behavioural I2C responder and sample model.
// Define ACCEL_DEVID_CHECK_EN to exercise the DEVID check as well.
module tb_accel_poll_sequencer;
  import accel_poll_sequencer_pkg::*;

  localparam int unsigned PERIOD   = 1000;
  localparam int unsigned TIMEOUT  = 300;
  localparam int unsigned RESP_LAT = 50;
`ifdef ACCEL_DEVID_CHECK_EN
  localparam int unsigned N_INIT = 4;
`else
  localparam int unsigned N_INIT = 3;
`endif

  logic clk = 1'b0;
  logic rst, enable, i2c_ready;
  logic resp_fin, stray_fin;
  logic i2c_finished;
  logic [7:0] i2c_read_data;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr, i2c_write_data;
  logic i2c_r_w, i2c_start, accel_valid, busy, error;
  logic [15:0] accel_x, accel_y, accel_z;
  accel_seq_state_e dbg_state;

  assign i2c_finished = resp_fin | stray_fin;

  accel_poll_sequencer #(
    .POLL_PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SENSOR_ADDR(7'h1D)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .i2c_ready(i2c_ready),
    .i2c_finished(i2c_finished), .i2c_read_data(i2c_read_data),
    .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_r_w(i2c_r_w),
    .i2c_write_data(i2c_write_data), .i2c_start(i2c_start),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .accel_valid(accel_valid),
    .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  logic [7:0] mem [256];
  bit hang = 1'b0;

  typedef struct { logic [6:0] dev; logic [7:0] ra; logic rw; logic [7:0] wd; int unsigned at; } txn_t;
  typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] z; } smp_t;
  txn_t txq[$];
  smp_t vq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (accel_valid === 1'b1) vq.push_back('{accel_x, accel_y, accel_z});

  // Responder: capture each start, watch field stability, finish RESP_LAT cycles later.
  initial begin
    resp_fin = 1'b0;
    i2c_read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1) begin
        txn_t t;
        bit stable;
        bit one_wide;
        t = '{i2c_dev_addr, i2c_reg_addr, i2c_r_w, i2c_write_data, cyc};
        txq.push_back(t);
        stable = 1'b1;
        one_wide = 1'b1;
        for (int k = 1; k <= RESP_LAT; k++) begin
          @(negedge clk);
          if (i2c_start !== 1'b0) one_wide = 1'b0;
          if (i2c_reg_addr !== t.ra || i2c_r_w !== t.rw || i2c_write_data !== t.wd ||
              i2c_dev_addr !== t.dev) stable = 1'b0;
        end
        check("start_one_cycle", 32'(one_wide), 32'd1);
        check("fields_stable", 32'(stable), 32'd1);
        if (!hang) begin
          resp_fin = 1'b1;
          i2c_read_data = t.rw ? mem[t.ra] : 8'h00;
          @(negedge clk);
          resp_fin = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(budget) && !ok; i++) begin
      tick();
      ok = (vq.size() != 0);
    end
  endtask

  task automatic wait_state(input accel_seq_state_e s, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(budget) && !ok; i++) begin
      tick();
      ok = (dbg_state == s);
    end
  endtask

  task automatic wait_txns(input int n, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(budget) && !ok; i++) begin
      tick();
      ok = (txq.size() >= n);
    end
  endtask

  // Expected init request {reg, r_w, data} for step i, straight from the sensor setup table.
  function automatic logic [16:0] init_exp(input int i);
    int w;
`ifdef ACCEL_DEVID_CHECK_EN
    if (i == 0) return {8'h00, 1'b1, 8'h00};
    w = i - 1;
`else
    w = i;
`endif
    case (w)
      0:       return {8'h31, 1'b0, 8'h0B};
      1:       return {8'h2C, 1'b0, 8'h0A};
      default: return {8'h2D, 1'b0, 8'h08};
    endcase
  endfunction

  task automatic check_init(input int base);
    logic [16:0] e;
    for (int i = 0; i < int'(N_INIT); i++) begin
      e = init_exp(i);
      check("init_present", 32'(txq.size() > base + i), 32'd1);
      if (txq.size() <= base + i) break;
      check("init_dev", 32'(txq[base+i].dev), 32'h1D);
      check("init_reg", 32'(txq[base+i].ra), 32'(e[16:9]));
      check("init_rw", 32'(txq[base+i].rw), 32'(e[8]));
      if (e[8] == 1'b0) check("init_data", 32'(txq[base+i].wd), 32'(e[7:0]));
    end
  endtask

  task automatic check_burst(input int base);
    for (int i = 0; i < 6; i++) begin
      check("read_present", 32'(txq.size() > base + i), 32'd1);
      if (txq.size() <= base + i) break;
      check("read_reg", 32'(txq[base+i].ra), 32'h32 + 32'(i));
      check("read_rw", 32'(txq[base+i].rw), 32'd1);
    end
  endtask

  task automatic check_sample(input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez);
    smp_t s;
    repeat (3) tick();
    check("valid_count", 32'(vq.size()), 32'd1);
    if (vq.size() != 0) begin
      s = vq.pop_front();
      check("accel_x", 32'(s.x), 32'(ex));
      check("accel_y", 32'(s.y), 32'(ey));
      check("accel_z", 32'(s.z), 32'(ez));
    end
    vq.delete();
  endtask

  task automatic load_burst(output logic [15:0] ex, output logic [15:0] ey, output logic [15:0] ez);
    for (int r = 0; r < 6; r++) mem[8'h32 + 8'(r)] = 8'($urandom);
    ex = {mem[8'h33], mem[8'h32]};
    ey = {mem[8'h35], mem[8'h34]};
    ez = {mem[8'h37], mem[8'h36]};
  endtask

  initial begin
    bit ok;
    int unsigned prev_start;
    int unsigned t0;
    logic [15:0] ex, ey, ez;
    stray_fin = 1'b0;
    rst = 1'b0;
    enable = 1'b0;
    i2c_ready = 1'b1;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hE5;
    repeat (4) tick();

    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_start", 32'(i2c_start), 32'd0);
    check("rst_valid", 32'(accel_valid), 32'd0);
    check("rst_dev_addr", 32'(i2c_dev_addr), 32'h1D);
    check("rst_reg_addr", 32'(i2c_reg_addr), 32'd0);
    check("rst_accel", 32'({accel_x, accel_y}), 32'd0);
    check("rst_accel_z", 32'(accel_z), 32'd0);
    rst = 1'b1;
    tick();

`ifdef ACCEL_DEVID_CHECK_EN
    mem[8'h00] = 8'hE4;
    enable = 1'b1;
    wait_state(ST_ERROR, 500, ok);
    check("devid_bad_error_state", 32'(ok), 32'd1);
    check("devid_bad_error_flag", 32'(error), 32'd1);
    repeat (20) tick();
    check("devid_bad_no_writes", 32'(txq.size()), 32'd1);
    enable = 1'b0;
    wait_state(ST_IDLE, 10, ok);
    check("devid_bad_idle", 32'(ok), 32'd1);
    txq.delete();
    mem[8'h00] = 8'hE5;
`endif

    // First run: init table then the fixed sample burst.
    mem[8'h32] = 8'h34; mem[8'h33] = 8'h12; mem[8'h34] = 8'hFF;
    mem[8'h35] = 8'hFF; mem[8'h36] = 8'h00; mem[8'h37] = 8'h80;
    enable = 1'b1;
    wait_valid(4000, ok);
    check("first_valid_seen", 32'(ok), 32'd1);
    check("first_txn_count", 32'(txq.size()), 32'(N_INIT + 6));
    check_init(0);
    check_burst(int'(N_INIT));
    check_sample(16'h1234, 16'hFFFF, 16'h8000);
    prev_start = (txq.size() > N_INIT) ? txq[N_INIT].at : 0;

    // Randomized bursts, each starting exactly one period after the previous one.
    for (int b = 0; b < 3; b++) begin
      txq.delete();
      load_burst(ex, ey, ez);
      wait_valid(PERIOD + 500, ok);
      check("burst_valid_seen", 32'(ok), 32'd1);
      check("burst_txn_count", 32'(txq.size()), 32'd6);
      check_burst(0);
      if (txq.size() != 0) begin
        check("burst_period", txq[0].at - prev_start, PERIOD);
        prev_start = txq[0].at;
      end
      check_sample(ex, ey, ez);
    end

    // A finished pulse while no transaction is outstanding must be ignored.
    txq.delete();
    check("pre_stray_state", 32'(dbg_state), 32'(ST_PERIOD_WAIT));
    check("pre_stray_busy", 32'(busy), 32'd1);
    stray_fin = 1'b1;
    tick();
    stray_fin = 1'b0;
    repeat (2) tick();
    check("stray_ignored", 32'(dbg_state), 32'(ST_PERIOD_WAIT));
    check("stray_no_start", 32'(txq.size()), 32'd0);

    // Drop enable during the third read: that read completes, the burst is discarded.
    wait_txns(3, PERIOD + 500, ok);
    check("third_read_seen", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_state(ST_IDLE, 200, ok);
    check("abort_idle", 32'(ok), 32'd1);
    if (txq.size() >= 3) check("abort_idle_cycle", cyc - txq[2].at, RESP_LAT + 1);
    repeat (2 * PERIOD) tick();
    check("abort_no_valid", 32'(vq.size()), 32'd0);
    check("abort_txn_count", 32'(txq.size()), 32'd3);
    check("abort_busy", 32'(busy), 32'd0);
    vq.delete();

    // Re-enable: no re-init, polling resumes.
    txq.delete();
    load_burst(ex, ey, ez);
    enable = 1'b1;
    wait_valid(PERIOD + 600, ok);
    check("resume_valid_seen", 32'(ok), 32'd1);
    check("resume_no_init", 32'(txq.size()), 32'd6);
    check_burst(0);
    check_sample(ex, ey, ez);

    // Responder goes silent: timeout after TIMEOUT wait cycles.
    hang = 1'b1;
    txq.delete();
    wait_txns(1, PERIOD + 200, ok);
    check("hang_start_seen", 32'(ok), 32'd1);
    t0 = (txq.size() != 0) ? txq[0].at : cyc;
    wait_state(ST_ERROR, TIMEOUT + 100, ok);
    check("timeout_error_state", 32'(ok), 32'd1);
    check("timeout_cycle", cyc - t0, TIMEOUT);
    check("timeout_error_flag", 32'(error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    repeat (PERIOD + 100) tick();
    check("error_holds", 32'(dbg_state), 32'(ST_ERROR));
    check("error_no_start", 32'(txq.size()), 32'd1);
    enable = 1'b0;
    wait_state(ST_IDLE, 10, ok);
    check("error_exit_idle", 32'(ok), 32'd1);
    check("error_cleared", 32'(error), 32'd0);

    // Recovery re-runs the full init.
    hang = 1'b0;
    txq.delete();
    vq.delete();
    load_burst(ex, ey, ez);
    repeat (5) tick();
    enable = 1'b1;
    wait_valid(4000, ok);
    check("reinit_valid_seen", 32'(ok), 32'd1);
    check("reinit_txn_count", 32'(txq.size()), 32'(N_INIT + 6));
    check_init(0);
    check_sample(ex, ey, ez);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
